arp_cache_lookup: RTL and testbench

//  Parametrised ARP cache for the router output-port-lookup pipeline: maps next-hop IP to dest MAC.

---
 rtl/arp_cache_lookup_if.sv | 50 +++++
 rtl/arp_cache_lookup.sv | 164 ++++++++++++++++
 tb/tb_arp_cache_lookup.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_cache_lookup_if.sv
// Lookup handshake and host table-access bus for the ARP cache.
interface arp_cache_lookup_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned IP_W   = 32,
  parameter int unsigned MAC_W  = 48
);

  localparam int unsigned ENTRY_W = MAC_W + IP_W;

  // Lookup request / response
  logic                lkp_req_valid;
  logic                lkp_req_ready;
  logic [IP_W-1:0]     lkp_ip;
  logic                lkp_resp_valid;
  logic                lkp_hit;
  logic [MAC_W-1:0]    lkp_mac;
  logic [ADDR_W-1:0]   lkp_index;

  // Host table write
  logic                tbl_wr_req;
  logic                tbl_wr_clr;
  logic [ADDR_W-1:0]   tbl_wr_addr;
  logic [ENTRY_W-1:0]  tbl_wr_data;
  logic                tbl_wr_ack;

  // Host table read
  logic                tbl_rd_req;
  logic [ADDR_W-1:0]   tbl_rd_addr;
  logic [ENTRY_W:0]    tbl_rd_data;
  logic                tbl_rd_ack;

  // Requester side (pipeline upstream / host)
  modport master (
    output lkp_req_valid, lkp_ip,
    output tbl_wr_req, tbl_wr_clr, tbl_wr_addr, tbl_wr_data,
    output tbl_rd_req, tbl_rd_addr,
    input  lkp_req_ready, lkp_resp_valid, lkp_hit, lkp_mac, lkp_index,
    input  tbl_wr_ack, tbl_rd_data, tbl_rd_ack
  );

  // Cache side
  modport slave (
    input  lkp_req_valid, lkp_ip,
    input  tbl_wr_req, tbl_wr_clr, tbl_wr_addr, tbl_wr_data,
    input  tbl_rd_req, tbl_rd_addr,
    output lkp_req_ready, lkp_resp_valid, lkp_hit, lkp_mac, lkp_index,
    output tbl_wr_ack, tbl_rd_data, tbl_rd_ack
  );

endinterface

// File: rtl/arp_cache_lookup.sv
// ARP cache: resolves next-hop IP to destination MAC with a 2-cycle,
// fully pipelined lookup, host read/write access, entry aging and
// hit/miss statistics.
module arp_cache_lookup #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned IP_W   = 32,
  parameter int unsigned MAC_W  = 48,
  parameter int unsigned AGE_W  = 16
) (
  input  logic                 AXI_ACLK,
  input  logic                 AXI_RESETN,
  arp_cache_lookup_if.slave    bus,
  input  logic                 age_tick,
  input  logic [AGE_W-1:0]     age_limit,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int unsigned CNT_W = 32;

  // Table storage
  logic [DEPTH-1:0]    ent_valid;
  logic [MAC_W-1:0]    ent_mac [DEPTH];
  logic [IP_W-1:0]     ent_ip  [DEPTH];
  logic [AGE_W-1:0]    ent_age [DEPTH];

  // Pipeline state
  logic                accept_c;
  logic                s1_valid;
  logic [IP_W-1:0]     s1_ip;
  logic [DEPTH-1:0]    match_vec_c;
  logic                win_hit_c;
  logic [ADDR_W-1:0]   win_idx_c;
  logic [MAC_W-1:0]    win_mac_c;
  logic                refresh_c;
  logic [AGE_W-1:0]    age_next_c [DEPTH];

  // Host writes own the table for the cycle, so lookups stall behind them
  assign bus.lkp_req_ready = AXI_RESETN & ~bus.tbl_wr_req;
  assign accept_c          = bus.lkp_req_valid & bus.lkp_req_ready;

  // C0 -> C1: capture the accepted request
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      s1_valid <= 1'b0;
      s1_ip    <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_ip <= bus.lkp_ip;
      end
    end
  end

  // C1: parallel compare against the table as it stands this cycle
  always_comb begin
    match_vec_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match_vec_c[i] = ent_valid[i] && (ent_ip[i] == s1_ip);
    end
  end

  // C1: lowest matching index wins
  always_comb begin
    win_hit_c = 1'b0;
    win_idx_c = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (match_vec_c[i]) begin
        win_hit_c = 1'b1;
        win_idx_c = ADDR_W'(i);
      end
    end
  end

  // MAC is picked in C1 so a write landing at the end of C1 cannot alter it
  assign win_mac_c = win_hit_c ? ent_mac[win_idx_c] : '0;

  // C1 -> C2: register the response so it leaves straight from flops
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      bus.lkp_resp_valid <= 1'b0;
      bus.lkp_hit        <= 1'b0;
      bus.lkp_mac        <= '0;
      bus.lkp_index      <= '0;
    end else begin
      bus.lkp_resp_valid <= s1_valid;
      bus.lkp_hit        <= s1_valid & win_hit_c;
      bus.lkp_mac        <= (s1_valid & win_hit_c) ? win_mac_c : '0;
      bus.lkp_index      <= (s1_valid & win_hit_c) ? win_idx_c : '0;
    end
  end

  // C2: statistics, wrapping naturally at 2^32
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (bus.lkp_resp_valid) begin
      if (bus.lkp_hit) begin
        hit_count <= hit_count + CNT_W'(1);
      end else begin
        miss_count <= miss_count + CNT_W'(1);
      end
    end
  end

  // A hit delivered in C2 keeps its entry young
  assign refresh_c = bus.lkp_resp_valid & bus.lkp_hit;

  // Saturating age increment per entry
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      age_next_c[i] = (ent_age[i] == '1) ? ent_age[i] : ent_age[i] + AGE_W'(1);
    end
  end

  // Table update; per entry, write/clear beats hit refresh beats aging
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      ent_valid <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_mac[i] <= '0;
        ent_ip[i]  <= '0;
        ent_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (bus.tbl_wr_req && (bus.tbl_wr_addr == ADDR_W'(i))) begin
          ent_valid[i] <= ~bus.tbl_wr_clr;
          ent_age[i]   <= '0;
          if (!bus.tbl_wr_clr) begin
            {ent_mac[i], ent_ip[i]} <= bus.tbl_wr_data;
          end
        end else if (refresh_c && (bus.lkp_index == ADDR_W'(i))) begin
          ent_age[i] <= '0;
        end else if (age_tick && ent_valid[i]) begin
          ent_age[i] <= age_next_c[i];
          if ((age_limit != '0) && (age_next_c[i] >= age_limit)) begin
            ent_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Host access acknowledges; reads return the pre-write entry
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      bus.tbl_wr_ack  <= 1'b0;
      bus.tbl_rd_ack  <= 1'b0;
      bus.tbl_rd_data <= '0;
    end else begin
      bus.tbl_wr_ack <= bus.tbl_wr_req;
      bus.tbl_rd_ack <= bus.tbl_rd_req;
      if (bus.tbl_rd_req) begin
        bus.tbl_rd_data <= {ent_valid[bus.tbl_rd_addr],
                            ent_mac[bus.tbl_rd_addr],
                            ent_ip[bus.tbl_rd_addr]};
      end
    end
  end

endmodule

// File: tb/tb_arp_cache_lookup.sv
// Directed bench for arp_cache_lookup with a reference table model and a
// response scoreboard.
module tb_arp_cache_lookup;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned IP_W   = 32;
  localparam int unsigned MAC_W  = 48;
  localparam int unsigned AGE_W  = 16;

  logic               AXI_ACLK = 1'b0;
  logic               AXI_RESETN;
  logic               age_tick;
  logic [AGE_W-1:0]   age_limit;
  logic [31:0]        hit_count;
  logic [31:0]        miss_count;

  int errors = 0;
  int checks = 0;

  arp_cache_lookup_if #(.ADDR_W(ADDR_W), .IP_W(IP_W), .MAC_W(MAC_W)) bus ();

  arp_cache_lookup #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IP_W(IP_W), .MAC_W(MAC_W), .AGE_W(AGE_W)
  ) u_dut (
    .AXI_ACLK   (AXI_ACLK),
    .AXI_RESETN (AXI_RESETN),
    .bus        (bus),
    .age_tick   (age_tick),
    .age_limit  (age_limit),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  typedef struct packed {
    logic              hit;
    logic [ADDR_W-1:0] idx;
    logic [MAC_W-1:0]  mac;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  // Reference table
  logic              m_valid [DEPTH];
  logic [MAC_W-1:0]  m_mac   [DEPTH];
  logic [IP_W-1:0]   m_ip    [DEPTH];
  int unsigned       m_age   [DEPTH];
  int unsigned       exp_hits;
  int unsigned       exp_misses;

  localparam logic [IP_W-1:0]  IP_A  = 32'h0A00_0001;
  localparam logic [IP_W-1:0]  IP_B  = 32'h0A00_0002;
  localparam logic [IP_W-1:0]  IP_C  = 32'h0A00_0003;
  localparam logic [IP_W-1:0]  IP_Z  = 32'h0A00_000A;
  localparam logic [MAC_W-1:0] MAC3  = 48'h0011_2233_4455;
  localparam logic [MAC_W-1:0] MAC3B = 48'h0000_1111_2222;
  localparam logic [MAC_W-1:0] MAC4  = 48'h0404_0404_0404;
  localparam logic [MAC_W-1:0] MAC7  = 48'hAABB_CCDD_EEF7;
  localparam logic [MAC_W-1:0] MAC7N = 48'h7777_0000_7777;
  localparam logic [MAC_W-1:0] MACZ  = 48'hDEAD_BEEF_000A;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_valid[i] = 1'b0;
      m_mac[i]   = '0;
      m_ip[i]    = '0;
      m_age[i]   = 0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic m_write(input int a, input logic [MAC_W-1:0] mac, input logic [IP_W-1:0] ip,
                         input logic clr);
    m_valid[a] = ~clr;
    m_age[a]   = 0;
    if (!clr) begin
      m_mac[a] = mac;
      m_ip[a]  = ip;
    end
  endtask

  task automatic m_tick();
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (m_valid[i]) begin
        if (m_age[i] < 65535) m_age[i]++;
        if (age_limit != '0 && m_age[i] >= int'(age_limit)) m_valid[i] = 1'b0;
      end
    end
  endtask

  // Predicted response for a lookup compared against the current model
  task automatic push_exp(input logic [IP_W-1:0] ip);
    exp_t e;
    e = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!e.hit && m_valid[i] && m_ip[i] == ip) begin
        e.hit = 1'b1;
        e.idx = ADDR_W'(i);
        e.mac = m_mac[i];
      end
    end
    if (e.hit) begin
      exp_hits++;
      m_age[e.idx] = 0;
    end else begin
      exp_misses++;
    end
    q.push_back(e);
  endtask

  task automatic do_write(input int a, input logic [MAC_W-1:0] mac, input logic [IP_W-1:0] ip,
                          input logic clr);
    bus.tbl_wr_req  = 1'b1;
    bus.tbl_wr_clr  = clr;
    bus.tbl_wr_addr = ADDR_W'(a);
    bus.tbl_wr_data = {mac, ip};
    @(negedge AXI_ACLK);
    bus.tbl_wr_req = 1'b0;
    bus.tbl_wr_clr = 1'b0;
    m_write(a, mac, ip, clr);
    chk("wr_ack", 128'(bus.tbl_wr_ack), 128'(1'b1));
  endtask

  task automatic read_chk(input string tag, input int a);
    bus.tbl_rd_req  = 1'b1;
    bus.tbl_rd_addr = ADDR_W'(a);
    @(negedge AXI_ACLK);
    bus.tbl_rd_req = 1'b0;
    chk("rd_ack", 128'(bus.tbl_rd_ack), 128'(1'b1));
    chk(tag, 128'(bus.tbl_rd_data), 128'({m_valid[a], m_mac[a], m_ip[a]}));
  endtask

  task automatic lookup(input logic [IP_W-1:0] ip);
    bus.lkp_req_valid = 1'b1;
    bus.lkp_ip        = ip;
    #1;
    chk("req_ready", 128'(bus.lkp_req_ready), 128'(1'b1));
    push_exp(ip);
    @(negedge AXI_ACLK);
    bus.lkp_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge AXI_ACLK);
    chk("drain", 128'(q.size() == 0), 128'(1'b1));
    repeat (2) @(negedge AXI_ACLK);
  endtask

  task automatic tick();
    age_tick = 1'b1;
    @(negedge AXI_ACLK);
    age_tick = 1'b0;
    m_tick();
    @(negedge AXI_ACLK);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_hits"}, 128'(hit_count), 128'(exp_hits));
    chk({tag, "_misses"}, 128'(miss_count), 128'(exp_misses));
  endtask

  // Response monitor: every response must match the oldest prediction
  always @(negedge AXI_ACLK) begin
    if (bus.lkp_resp_valid === 1'b1) begin
      chk("resp_pending", 128'(q.size() != 0), 128'(1'b1));
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("resp_hit", 128'(bus.lkp_hit), 128'(mon_e.hit));
        chk("resp_index", 128'(bus.lkp_index), 128'(mon_e.idx));
        chk("resp_mac", 128'(bus.lkp_mac), 128'(mon_e.mac));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    AXI_RESETN        = 1'b0;
    age_tick          = 1'b0;
    age_limit         = '0;
    bus.lkp_req_valid = 1'b0;
    bus.lkp_ip        = '0;
    bus.tbl_wr_req    = 1'b0;
    bus.tbl_wr_clr    = 1'b0;
    bus.tbl_wr_addr   = '0;
    bus.tbl_wr_data   = '0;
    bus.tbl_rd_req    = 1'b0;
    bus.tbl_rd_addr   = '0;
    m_reset();
    repeat (3) @(negedge AXI_ACLK);

    // Reset state
    chk("rst_ready", 128'(bus.lkp_req_ready), 128'(1'b0));
    chk("rst_resp_valid", 128'(bus.lkp_resp_valid), 128'(1'b0));
    chk("rst_wr_ack", 128'(bus.tbl_wr_ack), 128'(1'b0));
    chk("rst_rd_data", 128'(bus.tbl_rd_data), 128'(0));
    chk_counts("rst");
    AXI_RESETN = 1'b1;
    @(negedge AXI_ACLK);

    // 1: lookup on an empty table misses
    lookup(IP_A);
    drain();
    chk_counts("t1");

    // 2: single entry hit
    do_write(3, MAC3, IP_A, 1'b0);
    lookup(IP_A);
    drain();
    chk_counts("t2");

    // 3: lowest index wins; cleared entry with matching ip is ignored
    do_write(7, MAC7, IP_B, 1'b0);
    do_write(3, MAC3B, IP_B, 1'b0);
    lookup(IP_B);
    do_write(3, '0, '0, 1'b1);
    lookup(IP_B);
    lookup(IP_A);
    drain();
    read_chk("rd_cleared_idx3", 3);
    chk_counts("t3");

    // Read and write to the same address in one cycle returns the old entry
    bus.tbl_wr_req  = 1'b1;
    bus.tbl_wr_addr = ADDR_W'(7);
    bus.tbl_wr_data = {MAC7N, IP_B};
    bus.tbl_rd_req  = 1'b1;
    bus.tbl_rd_addr = ADDR_W'(7);
    @(negedge AXI_ACLK);
    bus.tbl_wr_req = 1'b0;
    bus.tbl_rd_req = 1'b0;
    chk("rw_same_rd", 128'(bus.tbl_rd_data), 128'({1'b1, MAC7, IP_B}));
    chk("rw_same_ack", 128'({bus.tbl_rd_ack, bus.tbl_wr_ack}), 128'(2'b11));
    m_write(7, MAC7N, IP_B, 1'b0);
    read_chk("rd_after_rw", 7);

    // 4: back-to-back lookups, host write stalls the second one
    lookup(IP_Z);
    bus.lkp_req_valid = 1'b1;
    bus.lkp_ip        = IP_B;
    bus.tbl_wr_req    = 1'b1;
    bus.tbl_wr_addr   = ADDR_W'(10);
    bus.tbl_wr_data   = {MACZ, IP_Z};
    #1;
    chk("stall_ready", 128'(bus.lkp_req_ready), 128'(1'b0));
    @(negedge AXI_ACLK);
    bus.tbl_wr_req = 1'b0;
    m_write(10, MACZ, IP_Z, 1'b0);
    lookup(IP_B);
    lookup(IP_Z);
    drain();
    chk_counts("t4");

    // 5: aging expires an idle entry; a hit between ticks keeps it alive
    age_limit = AGE_W'(3);
    do_write(4, MAC4, IP_A, 1'b0);
    tick();
    tick();
    read_chk("age_alive_2ticks", 4);
    tick();
    read_chk("age_expired", 4);
    lookup(IP_A);
    drain();
    do_write(4, MAC4, IP_A, 1'b0);
    tick();
    tick();
    lookup(IP_A);
    drain();
    tick();
    read_chk("age_refreshed", 4);
    lookup(IP_A);
    drain();
    chk_counts("t5");
    age_limit = '0;

    // 6: reset while a lookup sits in C1
    do_write(7, MAC7, IP_C, 1'b0);
    lookup(IP_C);
    AXI_RESETN = 1'b0;
    q.delete();
    m_reset();
    @(negedge AXI_ACLK);
    chk("mid_rst_ready", 128'(bus.lkp_req_ready), 128'(1'b0));
    @(negedge AXI_ACLK);
    AXI_RESETN = 1'b1;
    repeat (4) @(negedge AXI_ACLK);
    chk_counts("t6");
    read_chk("t6_tbl_empty", 7);
    lookup(IP_C);
    drain();
    chk_counts("t6_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
